// File: rtl/demux1_4_frame.sv
// demux1_4_frame
//   Registered 1:4 demultiplexer and frame assembler. Each accepted lane
//   value I is written into one of four lane registers. The lane comes from
//   the select S, or from an internal round-robin counter when auto_en=1.
//   Once all four lanes are filled, the assembled word is presented on D
//   with a valid/ready handshake.
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   I            lane data in (WIDTH bits)
//   S            lane select, used when auto_en=0
//   in_valid     I/S valid this cycle
//   in_ready     block can accept I this cycle (combinational)
//   auto_en      1: lane = internal counter, 0: lane = S
//   D            assembled lanes; lane k at D[k*WIDTH +: WIDTH]
//   lane_wr      one-hot pulse marking the lane written in the previous cycle
//   frame_valid  all four lanes filled; D is stable
//   frame_ready  consumer accepts the frame
module demux1_4_frame #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   I,
    input  logic [1:0]         S,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               auto_en,
    output logic [4*WIDTH-1:0] D,
    output logic [3:0]         lane_wr,
    output logic               frame_valid,
    input  logic               frame_ready
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [4*WIDTH-1:0] data_q, data_d;
    logic [3:0]         lane_wr_q, lane_wr_d;
    logic [3:0]         filled_q, filled_d;
    logic [1:0]         cnt_q, cnt_d;

    logic       wr;
    logic       pop;
    logic [1:0] lane;
    logic [3:0] lane_oh;

    assign frame_valid = (state_q == FULL);
    assign in_ready    = !frame_valid || frame_ready;
    assign wr          = in_valid && in_ready;
    assign pop         = frame_valid && frame_ready;
    assign lane        = auto_en ? cnt_q : S;
    assign lane_oh     = 4'b0001 << lane;

    assign D       = data_q;
    assign lane_wr = lane_wr_q;

    always_comb begin
        data_d    = data_q;
        lane_wr_d = '0;
        filled_d  = filled_q;
        cnt_d     = cnt_q;
        state_d   = state_q;

        // A pop clears the fill tracking first so that a write in the same
        // cycle starts the next frame (filled one-hot, cnt 0 -> 1).
        if (pop) begin
            filled_d = '0;
            cnt_d    = '0;
        end

        if (wr) begin
            data_d[int'(lane)*WIDTH +: WIDTH] = I;
            lane_wr_d = lane_oh;
            filled_d  = filled_d | lane_oh;
            if (auto_en) begin
                cnt_d = cnt_d + 2'd1;
            end
        end

        // frame_valid rises in the same cycle D shows the last lane.
        state_d = (filled_d == 4'b1111) ? FULL : FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            data_q    <= '0;
            lane_wr_q <= '0;
            filled_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            lane_wr_q <= lane_wr_d;
            filled_q  <= filled_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_demux1_4_frame.sv
// tb_demux1_4_frame
//   Self-checking bench for demux1_4_frame with WIDTH=1. A behavioural model
//   computes the expected D / lane_wr / frame_valid for each driven cycle and
//   pushes them to a scoreboard queue; they are popped and compared once the
//   DUT has registered the cycle. Directed constant checks cover the
//   scenario results.
module tb_demux1_4_frame;

    localparam int unsigned W = 1;

    logic           clk;
    logic           rst;
    logic [W-1:0]   I;
    logic [1:0]     S;
    logic           in_valid;
    logic           in_ready;
    logic           auto_en;
    logic [4*W-1:0] D;
    logic [3:0]     lane_wr;
    logic           frame_valid;
    logic           frame_ready;

    demux1_4_frame #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .I          (I),
        .S          (S),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .auto_en    (auto_en),
        .D          (D),
        .lane_wr    (lane_wr),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] lw;
        logic       fv;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [3:0] m_d      = '0;
    logic [3:0] m_lw     = '0;
    logic [3:0] m_filled = '0;
    logic [1:0] m_cnt    = '0;
    logic       m_fv     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, update the model, push the expectation,
    // then compare after the edge.
    task automatic step(input logic r, input logic iv, input logic i_bit,
                        input logic [1:0] s, input logic ae, input logic fr);
        logic       rdy;
        logic       wr;
        logic [1:0] ln;
        exp_t       e;
        exp_t       got;
        @(negedge clk);
        rst = r; in_valid = iv; I = i_bit; S = s; auto_en = ae; frame_ready = fr;
        #1;
        rdy = !m_fv || fr;
        if (!r) check("in_ready", 32'(in_ready), 32'(rdy));

        if (r) begin
            m_d = '0; m_lw = '0; m_filled = '0; m_cnt = '0; m_fv = 1'b0;
        end else begin
            wr = iv && rdy;
            ln = ae ? m_cnt : s;
            if (m_fv && fr) begin
                m_filled = '0;
                m_cnt    = '0;
            end
            m_lw = '0;
            if (wr) begin
                m_d[ln]      = i_bit;
                m_filled[ln] = 1'b1;
                m_lw[ln]     = 1'b1;
                if (ae) m_cnt = m_cnt + 2'd1;
            end
            m_fv = (m_filled == 4'b1111);
        end
        e.d = m_d; e.lw = m_lw; e.fv = m_fv;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            got.d = D; got.lw = lane_wr; got.fv = frame_valid;
            check("D", 32'(got.d), 32'(e.d));
            check("lane_wr", 32'(got.lw), 32'(e.lw));
            check("frame_valid", 32'(got.fv), 32'(e.fv));
        end
    endtask

    initial begin
        rst = 1'b1; I = '0; S = '0; in_valid = 1'b0; auto_en = 1'b0; frame_ready = 1'b0;

        // 1. Reset held 2 cycles with in_valid=1
        step(1, 1, 1, 2'd0, 1, 0);
        step(1, 1, 1, 2'd0, 1, 0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 2. Auto mode fill: I = 1,0,1,1
        step(0, 1, 1, 2'd0, 1, 0);
        check("auto_lw0", 32'(lane_wr), 32'h1);
        step(0, 1, 0, 2'd0, 1, 0);
        check("auto_lw1", 32'(lane_wr), 32'h2);
        step(0, 1, 1, 2'd0, 1, 0);
        check("auto_lw2", 32'(lane_wr), 32'h4);
        step(0, 1, 1, 2'd0, 1, 0);
        check("auto_lw3", 32'(lane_wr), 32'h8);
        check("auto_D", 32'(D), 32'hD);
        check("auto_fv", 32'(frame_valid), 32'd1);
        check("auto_in_ready", 32'(in_ready), 32'd0);

        // 4. Backpressure for 3 cycles, then pop
        for (int k = 0; k < 3; k++) step(0, 1, 0, 2'd1, 1, 0);
        check("bp_D", 32'(D), 32'hD);
        check("bp_lw", 32'(lane_wr), 32'h0);
        step(0, 0, 0, 2'd0, 1, 1);
        check("pop_fv", 32'(frame_valid), 32'd0);

        // 5. Refill, then simultaneous pop and write
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 1, 1, 2'd0, 1, 0);
        check("refill_fv", 32'(frame_valid), 32'd1);
        step(0, 1, 0, 2'd0, 1, 1);
        check("sim_fv", 32'(frame_valid), 32'd0);
        check("sim_lw", 32'(lane_wr), 32'h1);
        check("sim_D0", 32'(D[0]), 32'd0);
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 1, 0, 2'd0, 1, 0);
        check("sim_D", 32'(D), 32'h6);
        check("sim_full", 32'(frame_valid), 32'd1);
        step(0, 0, 0, 2'd0, 1, 1);

        // 3. Addressed mode with a lane rewrite
        step(0, 1, 1, 2'd2, 0, 0);
        step(0, 1, 1, 2'd0, 0, 0);
        step(0, 1, 0, 2'd2, 0, 0);
        step(0, 1, 0, 2'd3, 0, 0);
        check("addr_fv_early", 32'(frame_valid), 32'd0);
        step(0, 1, 1, 2'd1, 0, 0);
        check("addr_D", 32'(D), 32'h3);
        check("addr_fv", 32'(frame_valid), 32'd1);
        step(0, 0, 0, 2'd0, 0, 1);

        // 6. Reset mid-frame
        step(0, 1, 1, 2'd0, 1, 0);
        step(0, 1, 1, 2'd0, 1, 0);
        step(1, 1, 1, 2'd0, 1, 0);
        check("mid_rst_D", 32'(D), 32'd0);
        step(0, 1, 1, 2'd3, 1, 0);
        check("mid_lw0", 32'(lane_wr), 32'h1);
        step(0, 1, 1, 2'd3, 1, 0);
        step(0, 1, 0, 2'd3, 1, 0);
        step(0, 1, 1, 2'd3, 1, 0);
        check("mid_D", 32'(D), 32'hB);
        check("mid_fv", 32'(frame_valid), 32'd1);

        // Idle cycle: no state change
        step(0, 0, 1, 2'd0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
